// File: rtl/nios_sys_pio_seg_scan.sv
// nios_sys_pio_seg_scan: Avalon-MM multiplexed 7-segment scanner; define SEG_SCAN_PWM_EN for BRIGHT/PWM dimming.
module nios_sys_pio_seg_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] dig
);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [32:0] DATA_M = (33'd1 << (4 * NUM_DIGITS)) - 33'd1;
    localparam logic [8:0] DIG_M = (9'd1 << NUM_DIGITS) - 9'd1;
    localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW != 0 ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW != 0 ? '1 : '0;
    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [31:0]           data_q, data_d;
    logic [7:0]            blank_q, blank_d, dp_q, dp_d;
    logic                  en_q, en_d;
    logic [2:0]            idx_q, idx_d;
    logic [PW-1:0]         pre_q, pre_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic                  we, pre_wrap, bright_ok, active;
    logic [3:0]            nib;
    logic [4:0]            bright_rd;
`ifdef SEG_SCAN_PWM_EN
    logic [4:0]            bright_q, bright_d;
    logic [3:0]            pwm_q, pwm_d;
`endif

    always_comb begin
        we        = chipselect && !write_n;
        data_d    = (we && address == 2'd0) ? writedata & DATA_M[31:0] : data_q;
        blank_d   = (we && address == 2'd1) ? writedata[7:0] & DIG_M[7:0] : blank_q;
        dp_d      = (we && address == 2'd1) ? writedata[15:8] & DIG_M[7:0] : dp_q;
        en_d      = (we && address == 2'd1) ? writedata[16] : en_q;
        pre_wrap  = pre_q == PW'(CLK_DIV - 1);
        pre_d     = pre_wrap ? '0 : pre_q + PW'(1);
        idx_d     = !pre_wrap ? idx_q : (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
`ifdef SEG_SCAN_PWM_EN
        bright_d  = (we && address == 2'd2) ? ((writedata[4:0] > 5'd16) ? 5'd16 : writedata[4:0]) : bright_q;
        pwm_d     = pwm_q + 4'd1;
        bright_ok = {1'b0, pwm_q} < bright_q;
        bright_rd = bright_q;
`else
        bright_ok = 1'b1;
        bright_rd = 5'd0;
`endif
        nib       = data_q[{idx_q, 2'b00} +: 4];
        // slot's first cycle stays dark so the previous digit's glyph never ghosts
        active    = en_q && !blank_q[idx_q] && bright_ok && pre_q != '0;
        seg_d     = active ? {dp_q[idx_q], GLYPH[nib]} ^ SEG_OFF : SEG_OFF;
        dig_d     = active ? (NUM_DIGITS'(1) << idx_q) ^ DIG_OFF : DIG_OFF;
        readdata  = address == 2'd0 ? data_q :
                    address == 2'd1 ? {15'd0, en_q, dp_q, blank_q} :
                    address == 2'd2 ? {27'd0, bright_rd} : {29'd0, idx_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= '0;
            blank_q  <= '0;
            dp_q     <= '0;
            en_q     <= 1'b0;
            idx_q    <= '0;
            pre_q    <= '0;
            seg_q    <= SEG_OFF;
            dig_q    <= DIG_OFF;
`ifdef SEG_SCAN_PWM_EN
            bright_q <= 5'd16;
            pwm_q    <= '0;
`endif
        end else begin
            data_q   <= data_d;
            blank_q  <= blank_d;
            dp_q     <= dp_d;
            en_q     <= en_d;
            idx_q    <= idx_d;
            pre_q    <= pre_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
`ifdef SEG_SCAN_PWM_EN
            bright_q <= bright_d;
            pwm_q    <= pwm_d;
`endif
        end
    end

    assign seg = seg_q;
    assign dig = dig_q;
endmodule

// File: tb/tb_nios_sys_pio_seg_scan.sv
// tb_nios_sys_pio_seg_scan: directed bench for the seven-segment scanner, 4 digits, 16 clks per slot.
module tb_nios_sys_pio_seg_scan;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  seg;
    logic [3:0]  dig;
    int          checks = 0;
    int          errors = 0;
    int          n_on;

    always #5 clk = ~clk;

    nios_sys_pio_seg_scan #(.NUM_DIGITS(4), .CLK_DIV(16)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .seg(seg), .dig(dig)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    // returns at the negedge where STATUS has just switched to t
    task automatic enter_slot(input logic [2:0] t);
        logic [2:0] p;
        bit ok;
        ok = 1'b0;
        address = 2'd3;
        #1;
        p = readdata[2:0];
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = readdata[2:0] == t && p != t;
            p = readdata[2:0];
        end
        if (!ok) chk("slot_timeout", {29'd0, p}, {29'd0, t});
    endtask

    task automatic count_on(output int n);
        n = 0;
        repeat (16) begin
            @(negedge clk);
            if (dig !== 4'hF) n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_dig", dig, 4'hF);
        chk_rd("rst_data", 2'd0, 32'h0);
        chk_rd("rst_ctrl", 2'd1, 32'h0);
`ifdef SEG_SCAN_PWM_EN
        chk_rd("rst_bright", 2'd2, 32'd16);
`else
        chk_rd("rst_bright", 2'd2, 32'd0);
`endif
        chk_rd("rst_status", 2'd3, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        wr(2'd0, 32'hABCD_1234);
        chk_rd("data_mask", 2'd0, 32'h0000_1234);
        wr(2'd1, 32'h0001_0000);
        chk_rd("ctrl_rb", 2'd1, 32'h0001_0000);

        enter_slot(3'd0);
        step(1);
        chk("d0_dead_dig", dig, 4'hF);
        chk("d0_dead_seg", seg, 8'hFF);
        step(1);
        chk("d0_dig", dig, 4'hE);
        chk("d0_seg", seg, 8'h99);
        step(10);
        chk("d0_mid_dig", dig, 4'hE);

        enter_slot(3'd3);
        step(2);
        chk("d3_dig", dig, 4'h7);
        chk("d3_seg", seg, 8'hF9);
        step(13);
        chk_rd("slot_len15", 2'd3, 32'd3);
        step(1);
        chk_rd("idx_wrap", 2'd3, 32'd0);

        wr(2'd1, 32'h0001_F2F4);
        chk_rd("ctrl_mask", 2'd1, 32'h0001_0204);
        enter_slot(3'd1);
        step(2);
        chk("dp_dig", dig, 4'hD);
        chk("dp_seg", seg, 8'h30);
        enter_slot(3'd2);
        step(2);
        chk("blank_dig", dig, 4'hF);
        chk("blank_seg", seg, 8'hFF);
        step(8);
        chk("blank_mid", dig, 4'hF);
        enter_slot(3'd3);
        step(2);
        chk("nodp_seg", seg, 8'hF9);

        wr(2'd1, 32'h0001_0000);
        enter_slot(3'd2);
        step(3);
        chk("d2_dig", dig, 4'hB);
        chk("d2_seg", seg, 8'hA4);
        wr(2'd0, 32'h0000_1934);
        chk("wr_lat0", seg, 8'hA4);
        step(1);
        chk("wr_lat1", seg, 8'h90);
        chk("wr_lat1_dig", dig, 4'hB);
        enter_slot(3'd0);
        step(2);
        chk("undisturbed_d0", seg, 8'h99);
        enter_slot(3'd3);
        step(2);
        chk("undisturbed_d3", seg, 8'hF9);

        wr(2'd1, 32'h0);
        step(2);
        chk("dis_dig", dig, 4'hF);
        chk("dis_seg", seg, 8'hFF);
        enter_slot(3'd1);
        step(2);
        chk("dis_scan_dig", dig, 4'hF);
        wr(2'd1, 32'h0001_0000);

`ifdef SEG_SCAN_PWM_EN
        wr(2'd2, 32'd31);
        chk_rd("bright_sat", 2'd2, 32'd16);
        wr(2'd2, 32'd4);
        chk_rd("bright_rb", 2'd2, 32'd4);
        enter_slot(3'd1);
        count_on(n_on);
        chk("pwm4_on", n_on, 32'd3);
        wr(2'd2, 32'd0);
        enter_slot(3'd2);
        count_on(n_on);
        chk("pwm0_on", n_on, 32'd0);
        wr(2'd2, 32'd16);
        enter_slot(3'd3);
        count_on(n_on);
        chk("pwm16_on", n_on, 32'd15);
`else
        wr(2'd2, 32'd4);
        chk_rd("bright_ign", 2'd2, 32'd0);
        enter_slot(3'd1);
        count_on(n_on);
        chk("full_on", n_on, 32'd15);
`endif

        enter_slot(3'd2);
        step(3);
        chk("pre_rst_dig", dig, 4'hB);
        reset_n = 1'b0;
        #1;
        chk("arst_seg", seg, 8'hFF);
        chk("arst_dig", dig, 4'hF);
        chk_rd("arst_status", 2'd3, 32'd0);
        chk_rd("arst_data", 2'd0, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        chk_rd("rel_status", 2'd3, 32'd0);
        step(15);
        chk_rd("rel_pre15", 2'd3, 32'd0);
        step(1);
        chk_rd("rel_pre16", 2'd3, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
